// File: rtl/fetch_decode_pipe.sv
// ============================================================================
// fetch_decode_pipe : PC, F/D and D/X latches of the CPU front end
// Chooses freeze / flush / bubble / advance each cycle.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_decode_pipe #(
    parameter int          PC_WIDTH  = 32,
    parameter int          CNT_WIDTH = 16,
    parameter logic [31:0] NOP       = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_data,
    input  logic                 ld_stall,
    input  logic                 md_busy,
    input  logic                 br_taken,
    input  logic [PC_WIDTH-1:0]  br_target,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [31:0]          fd_ir,
    output logic [PC_WIDTH-1:0]  fd_pc,
    output logic [31:0]          dx_ir,
    output logic [PC_WIDTH-1:0]  dx_pc,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [1:0] MODE_ADVANCE = 2'd0;
    localparam logic [1:0] MODE_BUBBLE  = 2'd1;
    localparam logic [1:0] MODE_FLUSH   = 2'd2;
    localparam logic [1:0] MODE_FREEZE  = 2'd3;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]          mode;
    logic [PC_WIDTH-1:0] pc_inc;

    assign imem_addr = pc;
    assign pc_inc    = pc + PC_ONE;

    // md_busy outranks the redirect: execute cannot resolve a branch while
    // it is occupied by a multdiv, so br_taken is meaningless then.
    always_comb begin
        mode = MODE_ADVANCE;
        if (md_busy)
            mode = MODE_FREEZE;
        else if (br_taken)
            mode = MODE_FLUSH;
        else if (ld_stall)
            mode = MODE_BUBBLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc        <= '0;
            fd_ir     <= NOP;
            fd_pc     <= '0;
            dx_ir     <= NOP;
            dx_pc     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (mode)
                MODE_ADVANCE: begin
                    pc    <= pc_inc;
                    fd_ir <= imem_data;
                    fd_pc <= pc_inc;
                    dx_ir <= fd_ir;
                    dx_pc <= fd_pc;
                end
                MODE_BUBBLE: begin
                    dx_ir <= NOP;
                    dx_pc <= fd_pc;
                    if (stall_cnt != CNT_MAX)
                        stall_cnt <= stall_cnt + CNT_ONE;
                end
                MODE_FLUSH: begin
                    // Any coincident ld_stall belongs to a squashed instruction.
                    pc    <= br_target;
                    fd_ir <= NOP;
                    fd_pc <= br_target;
                    dx_ir <= NOP;
                    dx_pc <= br_target;
                    if (flush_cnt != CNT_MAX)
                        flush_cnt <= flush_cnt + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_pipe.sv
// ============================================================================
// tb_fetch_decode_pipe : directed vector bench for fetch_decode_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ld_stall, md_busy, br_taken;
    logic [31:0] br_target;

    logic [31:0] imem_addr, imem_data, pc, fd_ir, fd_pc, dx_ir, dx_pc;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_imem_addr, s_imem_data, s_pc, s_fd_ir, s_fd_pc, s_dx_ir, s_dx_pc;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Instruction memory: imem[i] = 0x1000_0000 + i
    assign imem_data   = 32'h1000_0000 + imem_addr;
    assign s_imem_data = 32'h1000_0000 + s_imem_addr;

    fetch_decode_pipe dut (
        .clock(clock), .reset_n(reset_n),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ld_stall(ld_stall), .md_busy(md_busy),
        .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .fd_ir(fd_ir), .fd_pc(fd_pc),
        .dx_ir(dx_ir), .dx_pc(dx_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_decode_pipe #(.CNT_WIDTH(4)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .imem_addr(s_imem_addr), .imem_data(s_imem_data),
        .ld_stall(ld_stall), .md_busy(md_busy),
        .br_taken(br_taken), .br_target(br_target),
        .pc(s_pc), .fd_ir(s_fd_ir), .fd_pc(s_fd_pc),
        .dx_ir(s_dx_ir), .dx_pc(s_dx_pc),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic        ld, md, br;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_fd_ir, e_fd_pc, e_dx_ir, e_dx_pc;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic ld, md, br, input logic [31:0] tgt,
                                input logic [31:0] p, fi, fp, di, dp,
                                input logic [15:0] sc, fc);
        vec_t v;
        v.ld = ld; v.md = md; v.br = br; v.tgt = tgt;
        v.e_pc = p; v.e_fd_ir = fi; v.e_fd_pc = fp; v.e_dx_ir = di; v.e_dx_pc = dp;
        v.e_stall = sc; v.e_flush = fc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        chk("pc", idx, pc, v.e_pc);
        chk("imem_addr", idx, imem_addr, v.e_pc);
        chk("fd_ir", idx, fd_ir, v.e_fd_ir);
        chk("fd_pc", idx, fd_pc, v.e_fd_pc);
        chk("dx_ir", idx, dx_ir, v.e_dx_ir);
        chk("dx_pc", idx, dx_pc, v.e_dx_pc);
        chk("stall_cnt", idx, {16'h0, stall_cnt}, {16'h0, v.e_stall});
        chk("flush_cnt", idx, {16'h0, flush_cnt}, {16'h0, v.e_flush});
    endtask

    task automatic drive_edge(input logic rn, ld, md, br, input logic [31:0] tgt);
        @(negedge clock);
        reset_n = rn; ld_stall = ld; md_busy = md; br_taken = br; br_target = tgt;
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] I0  = 32'h1000_0000;
    localparam logic [31:0] NOPW = 32'h0;

    initial begin
        //                 ld    md    br    tgt            pc             fd_ir          fd_pc          dx_ir          dx_pc          stall flush
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h1,         I0,            32'h1,         NOPW,          32'h0,         16'd0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h2,         I0+1,          32'h2,         I0,            32'h1,         16'd0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h3,         I0+2,          32'h3,         I0+1,          32'h2,         16'd0, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,         I0+3,          32'h4,         I0+2,          32'h3,         16'd0, 16'd0);
        // load-use bubble with imem[3] in decode
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h4,         I0+3,          32'h4,         NOPW,          32'h4,         16'd1, 16'd0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h5,         I0+4,          32'h5,         I0+3,          32'h4,         16'd1, 16'd0);
        // redirect to 0x40 with a coincident stall that must be dropped
        vecs[6]  = mk(1'b1, 1'b0, 1'b1, 32'h40,       32'h40,        NOPW,          32'h40,        NOPW,          32'h40,        16'd1, 16'd1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h41,        I0+32'h40,     32'h41,        NOPW,          32'h40,        16'd1, 16'd1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        // five frozen cycles with br_taken / ld_stall toggling
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h80,       32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h80,       32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h90,       32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'hA0,       32'h42,        I0+32'h41,     32'h42,        I0+32'h40,     32'h41,        16'd1, 16'd1);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h43,        I0+32'h42,     32'h43,        I0+32'h41,     32'h42,        16'd1, 16'd1);
        // PC wrap from all-ones
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NOPW,         32'hFFFF_FFFF, NOPW,          32'hFFFF_FFFF, 16'd1, 16'd2);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         32'h0FFF_FFFF, 32'h0,         NOPW,          32'hFFFF_FFFF, 16'd1, 16'd2);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h1,         I0,            32'h1,         32'h0FFF_FFFF, 32'h0,         16'd1, 16'd2);

        reset_n = 1'b0; ld_stall = 1'b0; md_busy = 1'b0; br_taken = 1'b0; br_target = '0;
        drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_all(-1, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOPW, 32'h0, NOPW, 32'h0, 16'd0, 16'd0));

        for (int i = 0; i < 18; i++) begin
            drive_edge(1'b1, vecs[i].ld, vecs[i].md, vecs[i].br, vecs[i].tgt);
            check_all(i, vecs[i]);
        end

        // 20 load-use bubbles: 16-bit counter reaches 21, 4-bit one pins at 15
        for (int i = 0; i < 20; i++)
            drive_edge(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_cnt_16", 100, {16'h0, stall_cnt}, 32'd21);
        chk("stall_cnt_sat", 101, {28'h0, s_stall_cnt}, 32'd15);
        chk("pc_hold_stall", 102, pc, 32'h1);
        chk("dx_ir_bubble", 103, dx_ir, NOPW);

        // 20 redirects: 4-bit flush counter saturates too
        for (int i = 0; i < 20; i++)
            drive_edge(1'b1, 1'b0, 1'b0, 1'b1, 32'h200 + i);
        chk("flush_cnt_16", 104, {16'h0, flush_cnt}, 32'd22);
        chk("flush_cnt_sat", 105, {28'h0, s_flush_cnt}, 32'd15);
        chk("pc_last_target", 106, pc, 32'h213);
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fd_ir_after_redirect", 107, fd_ir, I0 + 32'h213);

        // reset during a freeze with a redirect pending
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
        chk("freeze_pc", 108, pc, 32'h214);
        drive_edge(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        check_all(109, mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOPW, 32'h0, NOPW, 32'h0, 16'd0, 16'd0));
        chk("sat_stall_reset", 110, {28'h0, s_stall_cnt}, 32'd0);
        chk("sat_flush_reset", 111, {28'h0, s_flush_cnt}, 32'd0);

        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_reset_fd_ir", 112, fd_ir, I0);
        chk("post_reset_pc", 113, pc, 32'h1);
        drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_reset_dx_ir", 114, dx_ir, I0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
